// File: rtl/imem_loader.sv
// Byte-stream loader for the instruction memory: assembles little-endian 32-bit
// words, writes them word-aligned from BASE_ADDR, and holds the core in reset meanwhile.
module imem_loader #(
    parameter int unsigned DEPTH     = 64,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        we,
    output logic [31:0] wa,
    output logic [31:0] wd,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [7:0]  word_count,
    output logic        cpu_reset_n,
    output logic [2:0]  state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HDR   = 3'd1,
        S_BYTES = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  n_q;
    logic [1:0]  k_q;
    logic [31:0] wd_q;
    logic [7:0]  wc_q;
    logic        err_q;
    logic        hdr_bad;

    // Handshake: a byte moves on a rising edge where byte_valid && byte_ready.
    // byte_ready is a function of state only, so it never depends on byte_valid.
    assign hdr_bad = ({24'd0, byte_data} > DEPTH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        byte_ready = 1'b0;
        we         = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_HDR;
            end
            S_HDR: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                if (byte_valid) begin
                    if ((byte_data == 8'd0) || hdr_bad) state_d = S_DONE;
                    else                                state_d = S_BYTES;
                end
            end
            S_BYTES: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                if (byte_valid && (k_q == 2'd3)) state_d = S_WRITE;
            end
            S_WRITE: begin
                we   = 1'b1;
                busy = 1'b1;
                if ((wc_q + 8'd1) == n_q) state_d = S_DONE;
                else                      state_d = S_BYTES;
            end
            S_DONE: begin
                done = 1'b1;
                if (start) state_d = S_HDR;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_q   <= 8'd0;
            k_q   <= 2'd0;
            wd_q  <= 32'd0;
            wc_q  <= 8'd0;
            err_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        wc_q  <= 8'd0;
                        err_q <= 1'b0;
                        k_q   <= 2'd0;
                    end
                end
                S_HDR: begin
                    if (byte_valid) begin
                        n_q   <= byte_data;
                        err_q <= hdr_bad;
                        k_q   <= 2'd0;
                    end
                end
                S_BYTES: begin
                    if (byte_valid) begin
                        wd_q[{k_q, 3'b000} +: 8] <= byte_data;
                        k_q                      <= k_q + 2'd1;
                    end
                end
                S_WRITE: wc_q <= wc_q + 8'd1;
                default: ;
            endcase
        end
    end

    // The word counter doubles as the word index, so the address tracks words written.
    assign wa          = we ? (BASE_ADDR + {22'd0, wc_q, 2'b00}) : 32'd0;
    assign wd          = wd_q;
    assign error       = err_q;
    assign word_count  = wc_q;
    assign cpu_reset_n = (state_q == S_DONE) && !err_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed test-plan sessions plus randomized
// sessions checked against a word-list reference model built from the byte stream.
module tb_imem_loader;

  localparam int DEPTH = 64;
  localparam logic [31:0] BASE = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'd0;
  logic        byte_ready, we, busy, done, error, cpu_reset_n;
  logic [31:0] wa, wd;
  logic [7:0]  word_count;
  logic [2:0]  state_dbg;

  imem_loader #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .byte_valid(byte_valid),
    .byte_data(byte_data), .byte_ready(byte_ready), .we(we), .wa(wa), .wd(wd),
    .busy(busy), .done(done), .error(error), .word_count(word_count),
    .cpu_reset_n(cpu_reset_n), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int inv_bad = 0;
  logic [7:0]  stim_q[$];
  logic [63:0] got_q[$];
  logic [63:0] exp_q[$];

  // write monitor and sequencing invariants
  always @(negedge clk) begin
    if (we) got_q.push_back({wa, wd});
    if ((we && cpu_reset_n) || (wa[1:0] != 2'b00) || (we && byte_ready)) inv_bad++;
  end

  // reference model: header N, then N little-endian words at BASE + 4*i
  function automatic void build_exp();
    int h;
    logic [31:0] w;
    exp_q.delete();
    h = int'(stim_q[0]);
    if (h != 0 && h <= DEPTH)
      for (int i = 0; i < h; i++) begin
        w = {stim_q[4*i+4], stim_q[4*i+3], stim_q[4*i+2], stim_q[4*i+1]};
        exp_q.push_back({BASE + 32'(4*i), w});
      end
  endfunction

  function automatic void make_stim(input int h);
    stim_q.delete();
    stim_q.push_back(8'(h));
    if (h != 0 && h <= DEPTH)
      for (int i = 0; i < 4*h; i++) stim_q.push_back(8'($urandom));
  endfunction

  // drivers
  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // mode 0: valid every cycle, 1: toggled 1/0, 2: random gaps
  task automatic drive_stream(input int mode, input int glitch_idx, output bit ok);
    int idx = 0;
    bit lv = 0, lr = 0, tog = 1, glitched = 0, v;
    ok = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (lv && lr) idx++;
      if (idx >= stim_q.size()) begin ok = 1; break; end
      case (mode)
        0: v = 1;
        1: begin v = tog; tog = !tog; end
        default: v = ($urandom_range(0, 3) != 0);
      endcase
      byte_valid = v;
      byte_data  = v ? stim_q[idx] : 8'($urandom);
      if (idx == glitch_idx && !glitched) begin start = 1'b1; glitched = 1; end
      lv = v;
      lr = byte_ready;
    end
    byte_valid = 1'b0;
    start = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 0;
    for (int c = 0; c < 100; c++) begin
      if (done) begin ok = 1; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({byte_ready, we, wa, wd, busy, done, error, word_count, cpu_reset_n} !== 78'd0) begin
      n_bad++; $display("FAIL reset_in: outputs got %h need 0", {byte_ready, we, wa, wd, busy, done, error, word_count, cpu_reset_n});
    end
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    n_cmp++;
    if ({byte_ready, we, wa, wd, busy, done, error, word_count, cpu_reset_n} !== 78'd0) begin
      n_bad++; $display("FAIL reset_idle: outputs got %h need 0", {byte_ready, we, wa, wd, busy, done, error, word_count, cpu_reset_n});
    end
  endtask

  task automatic test_basic();
    bit ok1, ok2;
    stim_q = '{8'h02, 8'h03, 8'hA3, 8'hC4, 8'hFF, 8'h23, 8'hA6, 8'h64, 8'h00};
    exp_q  = '{{32'h0, 32'hFFC4A303}, {32'h4, 32'h0064A623}};
    got_q.delete();
    pulse_start();
    n_cmp++;
    if ({busy, done, cpu_reset_n, byte_ready} !== 4'b1001) begin
      n_bad++; $display("FAIL basic_hdr: busy/done/cpu_rst_n/ready got %b need 1001", {busy, done, cpu_reset_n, byte_ready});
    end
    drive_stream(0, -1, ok1);
    wait_done(ok2);
    n_cmp++;
    if (!(ok1 && ok2)) begin n_bad++; $display("FAIL basic_timeout: got %0d%0d need 11", ok1, ok2); end
    n_cmp++;
    if ({done, error, busy, cpu_reset_n, word_count} !== {4'b1001, 8'd2}) begin
      n_bad++; $display("FAIL basic_end: done/err/busy/crn/wc got %b need 1001_00000010", {done, error, busy, cpu_reset_n, word_count});
    end
    n_cmp++;
    if (got_q.size() != exp_q.size()) begin
      n_bad++; $display("FAIL basic_nwrites: got %0d need %0d", got_q.size(), exp_q.size());
    end else
      foreach (exp_q[j]) begin
        n_cmp++;
        if (got_q[j] !== exp_q[j]) begin n_bad++; $display("FAIL basic_write%0d: got %h need %h", j, got_q[j], exp_q[j]); end
      end
  endtask

  task automatic test_error();
    bit ok1, ok2;
    stim_q = '{8'h41};
    got_q.delete();
    pulse_start();
    drive_stream(0, -1, ok1);
    wait_done(ok2);
    repeat (3) @(negedge clk);
    n_cmp++;
    if (!(ok1 && ok2)) begin n_bad++; $display("FAIL err_timeout: got %0d%0d need 11", ok1, ok2); end
    n_cmp++;
    if ({done, error, cpu_reset_n, byte_ready, busy, word_count} !== {5'b11000, 8'd0}) begin
      n_bad++; $display("FAIL err_end: done/err/crn/ready/busy/wc got %b need 11000_00000000", {done, error, cpu_reset_n, byte_ready, busy, word_count});
    end
    n_cmp++;
    if (got_q.size() != 0) begin n_bad++; $display("FAIL err_nwrites: got %0d need 0", got_q.size()); end
  endtask

  task automatic test_toggle();
    bit ok1, ok2;
    stim_q = '{8'h01, 8'h33, 8'hE2, 8'h62, 8'h00};
    exp_q  = '{{32'h0, 32'h0062E233}};
    got_q.delete();
    pulse_start();
    drive_stream(1, -1, ok1);
    wait_done(ok2);
    n_cmp++;
    if (!(ok1 && ok2)) begin n_bad++; $display("FAIL tog_timeout: got %0d%0d need 11", ok1, ok2); end
    n_cmp++;
    if ({done, error, cpu_reset_n, word_count} !== {3'b101, 8'd1}) begin
      n_bad++; $display("FAIL tog_end: done/err/crn/wc got %b need 101_00000001", {done, error, cpu_reset_n, word_count});
    end
    n_cmp++;
    if (got_q.size() != 1 || got_q[0] !== exp_q[0]) begin
      n_bad++; $display("FAIL tog_write: got n=%0d first=%h need n=1 %h", got_q.size(), (got_q.size() > 0) ? got_q[0] : 64'd0, exp_q[0]);
    end
  endtask

  task automatic test_abort();
    bit ok1, ok2;
    make_stim(3);
    build_exp();
    while (stim_q.size() > 7) void'(stim_q.pop_back());
    got_q.delete();
    pulse_start();
    drive_stream(2, -1, ok1);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({byte_ready, we, wa, wd, busy, done, error, word_count, cpu_reset_n} !== 78'd0) begin
      n_bad++; $display("FAIL abort_reset: outputs got %h need 0", {byte_ready, we, wa, wd, busy, done, error, word_count, cpu_reset_n});
    end
    n_cmp++;
    if (!ok1 || got_q.size() != 1 || got_q[0] !== exp_q[0]) begin
      n_bad++; $display("FAIL abort_writes: got ok=%0d n=%0d need ok=1 n=1 %h", ok1, got_q.size(), exp_q[0]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    stim_q = '{8'h00};
    got_q.delete();
    pulse_start();
    drive_stream(0, -1, ok1);
    wait_done(ok2);
    n_cmp++;
    if ({ok1, ok2, done, error, cpu_reset_n, word_count} !== {5'b11101, 8'd0} || got_q.size() != 0) begin
      n_bad++; $display("FAIL abort_zero: ok/ok/done/err/crn/wc got %b n=%0d need 11101_00000000 n=0", {ok1, ok2, done, error, cpu_reset_n, word_count}, got_q.size());
    end
  endtask

  task automatic test_reload();
    bit ok1, ok2;
    make_stim(2);
    got_q.delete();
    pulse_start();
    drive_stream(0, -1, ok1);
    wait_done(ok2);
    n_cmp++;
    if ({ok1, ok2, cpu_reset_n, word_count} !== {3'b111, 8'd2}) begin
      n_bad++; $display("FAIL reload_first: ok/ok/crn/wc got %b need 111_00000010", {ok1, ok2, cpu_reset_n, word_count});
    end
    make_stim(1);
    build_exp();
    got_q.delete();
    pulse_start();
    n_cmp++;
    if ({cpu_reset_n, done, busy, error, word_count} !== {4'b0010, 8'd0}) begin
      n_bad++; $display("FAIL reload_start: crn/done/busy/err/wc got %b need 0010_00000000", {cpu_reset_n, done, busy, error, word_count});
    end
    drive_stream(0, 2, ok1);
    wait_done(ok2);
    n_cmp++;
    if ({ok1, ok2, cpu_reset_n, word_count} !== {3'b111, 8'd1}) begin
      n_bad++; $display("FAIL reload_end: ok/ok/crn/wc got %b need 111_00000001", {ok1, ok2, cpu_reset_n, word_count});
    end
    n_cmp++;
    if (got_q.size() != 1 || got_q[0] !== exp_q[0]) begin
      n_bad++; $display("FAIL reload_write: got n=%0d need n=1 %h", got_q.size(), exp_q[0]);
    end
  endtask

  task automatic test_random();
    bit ok1, ok2, exp_err;
    int h;
    for (int it = 0; it < 10; it++) begin
      case (it)
        0: h = DEPTH;
        1: h = DEPTH + 1;
        2: h = 255;
        3: h = 0;
        default: h = $urandom_range(1, 12);
      endcase
      make_stim(h);
      build_exp();
      exp_err = (h > DEPTH);
      got_q.delete();
      pulse_start();
      drive_stream($urandom_range(0, 2), -1, ok1);
      wait_done(ok2);
      n_cmp++;
      if ({ok1, ok2, done, busy, error, cpu_reset_n} !== {4'b1110, exp_err, !exp_err}) begin
        n_bad++; $display("FAIL rnd%0d_status: ok/ok/done/busy/err/crn got %b need 1110%b%b", it, {ok1, ok2, done, busy, error, cpu_reset_n}, exp_err, !exp_err);
      end
      n_cmp++;
      if (int'(word_count) != exp_q.size()) begin
        n_bad++; $display("FAIL rnd%0d_wc: got %0d need %0d", it, word_count, exp_q.size());
      end
      n_cmp++;
      if (got_q.size() != exp_q.size()) begin
        n_bad++; $display("FAIL rnd%0d_nwrites: got %0d need %0d", it, got_q.size(), exp_q.size());
      end else
        foreach (exp_q[j]) begin
          n_cmp++;
          if (got_q[j] !== exp_q[j]) begin n_bad++; $display("FAIL rnd%0d_write%0d: got %h need %h", it, j, got_q[j], exp_q[j]); end
        end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_error();
    test_toggle();
    test_abort();
    test_reload();
    test_random();
    n_cmp++;
    if (inv_bad != 0) begin n_bad++; $display("FAIL invariants: violations got %0d need 0", inv_bad); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Write-side companion to the read-only instruction memory: receives a byte stream and assembles little-endian 32-bit instruction words.
- Drives the instruction memory write port (we/wa/wd) with word-aligned byte addresses.
- Holds the single-cycle core in reset while loading; releases it once the program is in memory.
- Sits between the board-level byte source (UART RX or testbench) and the instruction memory.

Parameters:
- DEPTH, 64, instruction memory capacity in 32-bit words; maximum accepted load length.
- BASE_ADDR, 32'h0000_0000, byte address written for word 0; must be a multiple of 4.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse that begins a load session.
- byte_valid  input  1  byte_data is valid this cycle.
- byte_data  input  8  incoming stream byte.
- byte_ready  output  1  loader accepts a byte this cycle; a transfer occurs when byte_valid && byte_ready.
- we  output  1  instruction memory write enable, one-cycle pulse per word.
- wa  output  32  byte address for the write, word-aligned.
- wd  output  32  assembled instruction word.
- busy  output  1  load session in progress.
- done  output  1  last session completed (successfully or with error).
- error  output  1  last session's header exceeded DEPTH.
- word_count  output  8  words written in the current or last session.
- cpu_reset_n  output  1  active-low reset to the core; low whenever busy or never loaded.

Behaviour:
- Reset (rst_n low, async): state=IDLE; byte_ready=0, we=0, wa=0, wd=0, busy=0, done=0, error=0, word_count=0, cpu_reset_n=0.
- Reset asserted mid-session aborts it immediately. Memory contents already written are not cleared.
- States: IDLE, HDR, BYTES, WRITE, DONE.
- IDLE:
  - start=1 -> HDR; busy=1, done=0, error=0, word_count=0, cpu_reset_n=0.
- HDR:
  - byte_ready=1. On transfer, N=byte_data (unsigned word count).
  - N==0 -> DONE, no writes.
  - N>DEPTH -> DONE with error=1, no writes.
  - Otherwise -> BYTES; byte index k=0, word index i=0.
- BYTES:
  - byte_ready=1. On transfer, wd[8k+7:8k]=byte_data, then k++.
  - Transfer with k==3 -> WRITE; k wraps to 0.
  - byte_valid low: state holds with no timeout.
- WRITE:
  - byte_ready=0; we=1 for exactly this cycle; wa=BASE_ADDR+4*i; wd stable.
  - Next edge: i++, word_count++.
  - Next state is DONE if i+1==N, else BYTES.
  - Throughput is one word per 5 cycles minimum: 4 byte cycles plus 1 write cycle.
- DONE:
  - busy=0, done=1.
  - cpu_reset_n=1 if error==0; if error==1, cpu_reset_n stays 0.
  - start=1 -> HDR (reload); done, error, word_count cleared and cpu_reset_n=0 on that edge.
- start while in HDR, BYTES or WRITE is ignored.
- byte_valid outside HDR/BYTES is ignored; no byte is consumed (byte_ready=0).
- we is never high outside WRITE. wa[1:0] is always 00.
- i never exceeds DEPTH-1; the address range is BASE_ADDR .. BASE_ADDR+4*(DEPTH-1).
- Sequencing invariant: cpu_reset_n never rises in the same cycle as we.

Test Plan:
- Reset then idle 10 cycles -> all outputs 0, cpu_reset_n=0, byte_ready=0.
- start; stream 0x02, 03 A3 C4 FF, 23 A6 64 00 (valid every cycle) -> we pulses twice: (wa=0x0, wd=0xFFC4A303) and (wa=0x4, wd=0x0064A623). Then done=1, word_count=2, cpu_reset_n=1, busy=0.
- start; header 0x41 (65 > DEPTH=64) -> no we pulse, done=1, error=1, cpu_reset_n=0; byte_ready low afterwards.
- start; header 0x01; bytes 33 E2 62 00 with byte_valid toggled 1/0 each cycle -> single we at wa=0x0, wd=0x0062E233. No extra byte consumed during invalid cycles.
- Mid-word abort: header 0x03, 6 bytes sent, rst_n pulsed low asynchronously -> outputs return to reset values immediately. A new start with header 0x00 -> done=1, cpu_reset_n=1, word_count=0.
- Reload from DONE: after a 2-word load, start with header 0x01 and 4 bytes -> cpu_reset_n drops to 0 on the start edge, one we at wa=0x0, then rises after completion; start pulsed during BYTES has no effect.
